// File: rtl/cpu_phase_sequencer.sv
// Phase-enable sequencer for the ISA core: a prescaled tick drives one-hot phase
// strobes, gated by run/halt/single-step/wait-for-interrupt control.
module cpu_phase_sequencer #(
  parameter int DIV_WIDTH   = 8,
  parameter int NUM_PHASES  = 2,
  parameter int DEFAULT_DIV = 3,
  localparam int PHASE_W    = $clog2(NUM_PHASES)
) (
  input  logic                  CLOCK_50,
  input  logic                  reset_bar,
  input  logic                  div_load,
  input  logic [DIV_WIDTH-1:0]  div_value,
  input  logic [1:0]            mode,
  input  logic                  step_req,
  input  logic                  wfi,
  input  logic                  irq,
  output logic [NUM_PHASES-1:0] phase_en,
  output logic [PHASE_W-1:0]    phase_idx,
  output logic                  running,
  output logic [1:0]            state,
  output logic [15:0]           cycle_count
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_HALT = 2'b01,
    ST_STEP = 2'b10,
    ST_WFI  = 2'b11
  } state_t;

  localparam logic [PHASE_W-1:0]    LAST_PHASE = PHASE_W'(NUM_PHASES - 1);
  localparam logic [NUM_PHASES-1:0] PHASE_ONE  = NUM_PHASES'(1);

  state_t               state_q;
  state_t               nxt_state;
  logic [DIV_WIDTH-1:0] div_reg;
  logic [DIV_WIDTH-1:0] presc_cnt;
  logic [1:0]           step_sync;
  logic                 step_prev;
  logic                 step_active;
  logic                 nxt_active;
  logic                 issue_en;
  logic                 running_nxt;
  logic                 tick;
  logic                 boundary;
  logic                 step_rise;

  assign state     = state_q;
  assign tick      = !div_load && (presc_cnt == div_reg);
  assign boundary  = phase_en[NUM_PHASES-1];
  assign step_rise = step_sync[1] & ~step_prev;

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    nxt_state  = state_q;
    nxt_active = step_active;
    unique case (state_q)
      ST_RUN: begin
        if (boundary) begin
          if (irq)                nxt_state = ST_RUN;
          else if (wfi)           nxt_state = ST_WFI;
          else if (mode[0])       nxt_state = ST_HALT;
          else if (mode == 2'b10) nxt_state = ST_STEP;
        end
      end
      ST_HALT: begin
        if (mode == 2'b00)      nxt_state = ST_RUN;
        else if (mode == 2'b10) nxt_state = ST_STEP;
      end
      ST_STEP: begin
        if (step_active) begin
          // Mode and wfi are only honoured once the stepped instruction completes.
          if (boundary) begin
            nxt_active = 1'b0;
            if (wfi && !irq)        nxt_state = ST_WFI;
            else if (mode == 2'b00) nxt_state = ST_RUN;
            else if (mode[0])       nxt_state = ST_HALT;
          end
        end else begin
          if (mode == 2'b00) nxt_state = ST_RUN;
          else if (mode[0])  nxt_state = ST_HALT;
          else if (step_rise) nxt_active = 1'b1;
        end
      end
      ST_WFI: begin
        if (irq) nxt_state = ST_RUN;
      end
    endcase

    // At a boundary phase_idx is 0; a tick there may only open a new instruction if we keep issuing.
    issue_en    = (state_q == ST_RUN && nxt_state == ST_RUN) ||
                  (state_q == ST_STEP && step_active && !boundary);
    running_nxt = (nxt_state == ST_RUN) || (nxt_state == ST_STEP && nxt_active);
  end

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLOCK_50 or negedge reset_bar) begin
    if (!reset_bar) begin
      state_q     <= ST_RUN;
      div_reg     <= DIV_WIDTH'(DEFAULT_DIV);
      presc_cnt   <= '0;
      step_sync   <= '0;
      step_prev   <= 1'b0;
      step_active <= 1'b0;
      running     <= 1'b1;
      phase_en    <= '0;
      phase_idx   <= '0;
      cycle_count <= '0;
    end else begin
      // Two flops resynchronise the asynchronous step button before edge detection.
      step_sync <= {step_sync[0], step_req};
      step_prev <= step_sync[1];

      if (div_load) begin
        div_reg   <= div_value;
        presc_cnt <= '0;
      end else if (presc_cnt == div_reg) begin
        presc_cnt <= '0;
      end else begin
        presc_cnt <= presc_cnt + DIV_WIDTH'(1);
      end

      state_q     <= nxt_state;
      step_active <= nxt_active;
      running     <= running_nxt;

      if (tick && issue_en) begin
        phase_en  <= PHASE_ONE << phase_idx;
        phase_idx <= (phase_idx == LAST_PHASE) ? '0 : phase_idx + PHASE_W'(1);
      end else begin
        phase_en  <= '0;
      end

      if (boundary) cycle_count <= cycle_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Directed bench for cpu_phase_sequencer (NUM_PHASES=2, DEFAULT_DIV=3); expected values are
// hand-derived cycle counts from reset release, div loads and mode changes.
module tb_cpu_phase_sequencer;

  logic        CLOCK_50 = 1'b0;
  logic        reset_bar;
  logic        div_load;
  logic [7:0]  div_value;
  logic [1:0]  mode;
  logic        step_req;
  logic        wfi;
  logic        irq;
  logic [1:0]  phase_en;
  logic        phase_idx;
  logic        running;
  logic [1:0]  state;
  logic [15:0] cycle_count;

  int checks   = 0;
  int failures = 0;

  cpu_phase_sequencer #(
    .DIV_WIDTH  (8),
    .NUM_PHASES (2),
    .DEFAULT_DIV(3)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset_bar  (reset_bar),
    .div_load   (div_load),
    .div_value  (div_value),
    .mode       (mode),
    .step_req   (step_req),
    .wfi        (wfi),
    .irq        (irq),
    .phase_en   (phase_en),
    .phase_idx  (phase_idx),
    .running    (running),
    .state      (state),
    .cycle_count(cycle_count)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  // Step until a strobe appears or the budget runs out (pe stays 0 on timeout).
  task automatic wait_strobe(input int max, output int n, output logic [1:0] pe);
    n  = 0;
    pe = 2'b00;
    while (n < max) begin
      cyc(1);
      n++;
      if (phase_en != 2'b00) begin
        pe = phase_en;
        break;
      end
    end
  endtask

  initial begin
    int         n;
    int         strobes;
    logic [1:0] pe;

    reset_bar = 1'b0;
    div_load  = 1'b0;
    div_value = 8'd0;
    mode      = 2'b00;
    step_req  = 1'b0;
    wfi       = 1'b0;
    irq       = 1'b0;

    // Reset defaults
    #12;
    chk("rst_phase_en", 32'(phase_en), 32'h0);
    chk("rst_phase_idx", 32'(phase_idx), 32'h0);
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_running", 32'(running), 32'h1);
    chk("rst_count", 32'(cycle_count), 32'h0);
    cyc(1);
    reset_bar = 1'b1;

    // Default divide of 3: strobes at edges 4, 8, 12 after release
    cyc(3);
    chk("t1_idle_e3", 32'(phase_en), 32'h0);
    cyc(1);
    chk("t1_pe_e4", 32'(phase_en), 32'h1);
    chk("t1_idx_e4", 32'(phase_idx), 32'h1);
    cyc(4);
    chk("t1_pe_e8", 32'(phase_en), 32'h2);
    cyc(1);
    chk("t1_count_e9", 32'(cycle_count), 32'h1);
    chk("t1_state_e9", 32'(state), 32'h0);
    chk("t1_pe_e9", 32'(phase_en), 32'h0);
    cyc(3);
    chk("t1_pe_e12", 32'(phase_en), 32'h1);

    // Load divide 0: no strobe in the load cycle, then one every cycle
    cyc(1);
    div_load  = 1'b1;
    div_value = 8'd0;
    cyc(1);
    chk("t2_load_cycle", 32'(phase_en), 32'h0);
    div_load = 1'b0;
    cyc(1);
    chk("t2_pe_a", 32'(phase_en), 32'h2);
    cyc(1);
    chk("t2_pe_b", 32'(phase_en), 32'h1);
    cyc(1);
    chk("t2_pe_c", 32'(phase_en), 32'h2);
    chk("t2_count", 32'(cycle_count), 32'h2);

    // Load divide 7: strobes every 8 cycles
    div_load  = 1'b1;
    div_value = 8'd7;
    cyc(1);
    chk("t2_load7_cycle", 32'(phase_en), 32'h0);
    div_load = 1'b0;
    wait_strobe(20, n, pe);
    chk("t2_div7_gap1", 32'(n), 32'd8);
    chk("t2_div7_pe1", 32'(pe), 32'h1);
    wait_strobe(20, n, pe);
    chk("t2_div7_gap2", 32'(n), 32'd8);
    chk("t2_div7_pe2", 32'(pe), 32'h2);

    // Halt requested mid-instruction: second phase still issues
    wait_strobe(20, n, pe);
    chk("t3_pe_first", 32'(pe), 32'h1);
    mode = 2'b01;
    wait_strobe(20, n, pe);
    chk("t3_pe_finish", 32'(pe), 32'h2);
    chk("t3_gap_finish", 32'(n), 32'd8);
    cyc(1);
    chk("t3_state_halt", 32'(state), 32'h1);
    chk("t3_running_halt", 32'(running), 32'h0);
    chk("t3_count_halt", 32'(cycle_count), 32'h5);
    strobes = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (phase_en != 2'b00) strobes++;
    end
    chk("t3_halt_quiet", 32'(strobes), 32'd0);
    mode = 2'b00;
    cyc(1);
    chk("t3_state_resume", 32'(state), 32'h0);
    chk("t3_running_resume", 32'(running), 32'h1);
    wait_strobe(20, n, pe);
    chk("t3_resume_pe", 32'(pe), 32'h1);
    chk("t3_resume_gap", 32'(n), 32'd6);
    wait_strobe(20, n, pe);
    chk("t3_resume_pe2", 32'(pe), 32'h2);

    // Single-step: three pulses, one extra pulse mid-instruction
    mode = 2'b10;
    cyc(1);
    chk("t4_state_step", 32'(state), 32'h2);
    chk("t4_running_idle", 32'(running), 32'h0);
    chk("t4_count_start", 32'(cycle_count), 32'h6);
    strobes = 0;
    for (int k = 0; k < 3; k++) begin
      step_req = 1'b1;
      cyc(1);
      step_req = 1'b0;
      for (int j = 0; j < 49; j++) begin
        cyc(1);
        if (phase_en != 2'b00) strobes++;
        step_req = (k == 2 && phase_en == 2'b01);
      end
    end
    step_req = 1'b0;
    chk("t4_strobes", 32'(strobes), 32'd6);
    chk("t4_count_after", 32'(cycle_count), 32'h9);
    strobes = 0;
    for (int i = 0; i < 50; i++) begin
      cyc(1);
      if (phase_en != 2'b00) strobes++;
    end
    chk("t4_no_extra", 32'(strobes), 32'd0);
    chk("t4_count_final", 32'(cycle_count), 32'h9);
    chk("t4_state_final", 32'(state), 32'h2);

    // Wait-for-interrupt
    mode = 2'b00;
    cyc(1);
    chk("t5_state_run", 32'(state), 32'h0);
    wfi = 1'b1;
    wait_strobe(20, n, pe);
    chk("t5_pe_a", 32'(pe), 32'h1);
    wait_strobe(20, n, pe);
    chk("t5_pe_b", 32'(pe), 32'h2);
    cyc(1);
    chk("t5_state_wfi", 32'(state), 32'h3);
    chk("t5_running_wfi", 32'(running), 32'h0);
    mode = 2'b01;
    strobes = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      if (phase_en != 2'b00) strobes++;
    end
    chk("t5_wfi_quiet", 32'(strobes), 32'd0);
    chk("t5_wfi_ignores_mode", 32'(state), 32'h3);
    mode = 2'b00;
    wfi  = 1'b0;
    irq  = 1'b1;
    cyc(1);
    chk("t5_irq_wake", 32'(state), 32'h0);
    wait_strobe(20, n, pe);
    chk("t5_wake_pe", 32'(pe), 32'h1);
    wfi = 1'b1;
    wait_strobe(20, n, pe);
    chk("t5_both_pe", 32'(pe), 32'h2);
    cyc(1);
    chk("t5_both_state", 32'(state), 32'h0);
    chk("t5_both_running", 32'(running), 32'h1);
    wait_strobe(20, n, pe);
    chk("t5_both_next", 32'(pe), 32'h1);
    irq = 1'b0;
    wfi = 1'b0;
    wait_strobe(20, n, pe);
    chk("t5_tail_pe", 32'(pe), 32'h2);

    // cycle_count wrap with divide 0, then reset mid-phase
    div_load  = 1'b1;
    div_value = 8'd0;
    cyc(1);
    div_load = 1'b0;
    wait_strobe(4, n, pe);
    chk("t6_first_pe", 32'(pe), 32'h1);
    force dut.cycle_count = 16'hFC18;
    #1;
    release dut.cycle_count;
    cyc(2 * 999);
    chk("t6_count_ffff", 32'(cycle_count), 32'hFFFF);
    cyc(2);
    chk("t6_count_wrap", 32'(cycle_count), 32'h0);
    chk("t6_pe_before_rst", 32'(phase_en), 32'h1);
    reset_bar = 1'b0;
    #1;
    chk("t6_rst_pe", 32'(phase_en), 32'h0);
    chk("t6_rst_idx", 32'(phase_idx), 32'h0);
    chk("t6_rst_state", 32'(state), 32'h0);
    chk("t6_rst_running", 32'(running), 32'h1);
    chk("t6_rst_count", 32'(cycle_count), 32'h0);
    cyc(1);
    reset_bar = 1'b1;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
